// File: rtl/control_sequencer.sv
// control_sequencer
//   Moore-style hardwired control unit for a single-bus datapath. Steps
//   IDLE -> T0..T6 -> T0/HALT, one step per rising clk. T0..T2 fetch the
//   instruction, T3 onward execute it using opcode/register fields latched
//   from IR on the T2->T3 edge. Every output is decoded from the current
//   state and the latched fields only.
//
//   Optional build macro: ILLEGAL_TRAP_EN
//     defined   : an illegal opcode gives a quiet T3, sets the sticky
//                 'illegal' flag and halts.
//     undefined : an illegal opcode gives a quiet T3 and behaves as a NOP.
//
// Ports
//   clk     in   1  rising-edge clock
//   reset   in   1  synchronous active-high reset
//   run     in   1  start fetching from IDLE or HALT
//   stop    in   1  request a halt at the next instruction boundary
//   IR      in  32  instruction register contents from the datapath
//   r_in    out 16  one-hot register load strobes (bit n = Rn in)
//   r_out   out 16  one-hot register drive strobes (bit n = Rn out)
//   alu_op  out 13  one-hot ALU op: AND OR ADD SUB MUL DIV SHR SHRA SHL ROR ROL NEG NOT
//   ctl     out 16  PCout MARin IncPC Zin Zlowout Zhighout PCin Read
//                   MDRin MDRout IRin Yin HIin LOin HIout LOout
//   halted  out  1  high while in HALT
//   illegal out  1  sticky illegal-opcode flag
module control_sequencer (
    input  logic        clk,
    input  logic        reset,
    input  logic        run,
    input  logic        stop,
    input  logic [31:0] IR,
    output logic [15:0] r_in,
    output logic [15:0] r_out,
    output logic [12:0] alu_op,
    output logic [15:0] ctl,
    output logic        halted,
    output logic        illegal
);

    localparam logic [3:0] S_IDLE = 4'd0;
    localparam logic [3:0] S_T0   = 4'd1;
    localparam logic [3:0] S_T1   = 4'd2;
    localparam logic [3:0] S_T2   = 4'd3;
    localparam logic [3:0] S_T3   = 4'd4;
    localparam logic [3:0] S_T4   = 4'd5;
    localparam logic [3:0] S_T5   = 4'd6;
    localparam logic [3:0] S_T6   = 4'd7;
    localparam logic [3:0] S_HALT = 4'd8;

    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_AND  = 5'b00101;
    localparam logic [4:0] OP_OR   = 5'b00110;
    localparam logic [4:0] OP_ROR  = 5'b00111;
    localparam logic [4:0] OP_ROL  = 5'b01000;
    localparam logic [4:0] OP_SHR  = 5'b01001;
    localparam logic [4:0] OP_SHRA = 5'b01010;
    localparam logic [4:0] OP_SHL  = 5'b01011;
    localparam logic [4:0] OP_MUL  = 5'b01111;
    localparam logic [4:0] OP_DIV  = 5'b10000;
    localparam logic [4:0] OP_NEG  = 5'b10001;
    localparam logic [4:0] OP_NOT  = 5'b10010;

    localparam int unsigned ALU_AND  = 0;
    localparam int unsigned ALU_OR   = 1;
    localparam int unsigned ALU_ADD  = 2;
    localparam int unsigned ALU_SUB  = 3;
    localparam int unsigned ALU_MUL  = 4;
    localparam int unsigned ALU_DIV  = 5;
    localparam int unsigned ALU_SHR  = 6;
    localparam int unsigned ALU_SHRA = 7;
    localparam int unsigned ALU_SHL  = 8;
    localparam int unsigned ALU_ROR  = 9;
    localparam int unsigned ALU_ROL  = 10;
    localparam int unsigned ALU_NEG  = 11;
    localparam int unsigned ALU_NOT  = 12;

    localparam int unsigned C_PCOUT   = 0;
    localparam int unsigned C_MARIN   = 1;
    localparam int unsigned C_INCPC   = 2;
    localparam int unsigned C_ZIN     = 3;
    localparam int unsigned C_ZLOWOUT = 4;
    localparam int unsigned C_ZHIGHOUT= 5;
    localparam int unsigned C_PCIN    = 6;
    localparam int unsigned C_READ    = 7;
    localparam int unsigned C_MDRIN   = 8;
    localparam int unsigned C_MDROUT  = 9;
    localparam int unsigned C_IRIN    = 10;
    localparam int unsigned C_YIN     = 11;
    localparam int unsigned C_HIIN    = 12;
    localparam int unsigned C_LOIN    = 13;

    logic [3:0]  state;
    logic [3:0]  state_nxt;
    logic [4:0]  op_q;
    logic [3:0]  ra_q;
    logic [3:0]  rb_q;
    logic [3:0]  rc_q;
    logic        pending;
    logic        illegal_q;

    logic [12:0] alu_sel;
    logic        is_legal;
    logic        is_unary;
    logic        is_muldiv;
    logic        last_step;
    logic        trap;

    // IR[14:0] carries no information for this instruction set.
    logic        unused_ir;
    assign unused_ir = ^IR[14:0];

    function automatic logic [15:0] onehot16(input logic [3:0] idx);
        onehot16 = 16'h0001 << idx;
    endfunction

    // Opcode classification from the latched opcode.
    always_comb begin
        alu_sel   = '0;
        is_legal  = 1'b1;
        is_unary  = 1'b0;
        is_muldiv = 1'b0;
        case (op_q)
            OP_ADD:  alu_sel[ALU_ADD]  = 1'b1;
            OP_SUB:  alu_sel[ALU_SUB]  = 1'b1;
            OP_AND:  alu_sel[ALU_AND]  = 1'b1;
            OP_OR:   alu_sel[ALU_OR]   = 1'b1;
            OP_ROR:  alu_sel[ALU_ROR]  = 1'b1;
            OP_ROL:  alu_sel[ALU_ROL]  = 1'b1;
            OP_SHR:  alu_sel[ALU_SHR]  = 1'b1;
            OP_SHRA: alu_sel[ALU_SHRA] = 1'b1;
            OP_SHL:  alu_sel[ALU_SHL]  = 1'b1;
            OP_MUL: begin alu_sel[ALU_MUL] = 1'b1; is_muldiv = 1'b1; end
            OP_DIV: begin alu_sel[ALU_DIV] = 1'b1; is_muldiv = 1'b1; end
            OP_NEG: begin alu_sel[ALU_NEG] = 1'b1; is_unary  = 1'b1; end
            OP_NOT: begin alu_sel[ALU_NOT] = 1'b1; is_unary  = 1'b1; end
            default: is_legal = 1'b0;
        endcase
    end

    // Next-state logic. last_step marks the final step of an instruction,
    // where a pending (or same-cycle) stop diverts to HALT instead of T0.
    always_comb begin
        state_nxt = state;
        last_step = 1'b0;
        trap      = 1'b0;
        case (state)
            S_IDLE, S_HALT: if (run && !stop) state_nxt = S_T0;
            S_T0: state_nxt = S_T1;
            S_T1: state_nxt = S_T2;
            S_T2: state_nxt = S_T3;
            S_T3: begin
                if (!is_legal) begin
`ifdef ILLEGAL_TRAP_EN
                    trap      = 1'b1;
`else
                    last_step = 1'b1;
`endif
                end else begin
                    state_nxt = S_T4;
                end
            end
            S_T4: if (is_unary) last_step = 1'b1; else state_nxt = S_T5;
            S_T5: if (is_muldiv) state_nxt = S_T6; else last_step = 1'b1;
            S_T6: last_step = 1'b1;
            default: state_nxt = S_IDLE;
        endcase
        if (last_step || trap)
            state_nxt = (trap || pending || stop) ? S_HALT : S_T0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            op_q      <= '0;
            ra_q      <= '0;
            rb_q      <= '0;
            rc_q      <= '0;
            pending   <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == S_T2) begin
                op_q <= IR[31:27];
                ra_q <= IR[26:23];
                rb_q <= IR[22:19];
                rc_q <= IR[18:15];
            end
            if (state == S_IDLE || state == S_HALT || last_step || trap)
                pending <= 1'b0;
            else
                pending <= pending | stop;
`ifdef ILLEGAL_TRAP_EN
            if (trap)
                illegal_q <= 1'b1;
`endif
        end
    end

    // Output decode: state plus latched instruction fields only.
    always_comb begin
        r_in   = '0;
        r_out  = '0;
        alu_op = '0;
        ctl    = '0;
        case (state)
            S_T0: begin
                ctl[C_PCOUT] = 1'b1;
                ctl[C_MARIN] = 1'b1;
                ctl[C_INCPC] = 1'b1;
                ctl[C_ZIN]   = 1'b1;
            end
            S_T1: begin
                ctl[C_ZLOWOUT] = 1'b1;
                ctl[C_PCIN]    = 1'b1;
                ctl[C_READ]    = 1'b1;
                ctl[C_MDRIN]   = 1'b1;
            end
            S_T2: begin
                ctl[C_MDROUT] = 1'b1;
                ctl[C_IRIN]   = 1'b1;
            end
            S_T3: begin
                if (is_legal) begin
                    if (is_unary) begin
                        r_out      = onehot16(rb_q);
                        alu_op     = alu_sel;
                        ctl[C_ZIN] = 1'b1;
                    end else begin
                        r_out      = onehot16(is_muldiv ? ra_q : rb_q);
                        ctl[C_YIN] = 1'b1;
                    end
                end
            end
            S_T4: begin
                if (is_unary) begin
                    ctl[C_ZLOWOUT] = 1'b1;
                    r_in           = onehot16(ra_q);
                end else begin
                    r_out      = onehot16(is_muldiv ? rb_q : rc_q);
                    alu_op     = alu_sel;
                    ctl[C_ZIN] = 1'b1;
                end
            end
            S_T5: begin
                ctl[C_ZLOWOUT] = 1'b1;
                if (is_muldiv) ctl[C_LOIN] = 1'b1;
                else           r_in        = onehot16(ra_q);
            end
            S_T6: begin
                ctl[C_ZHIGHOUT] = 1'b1;
                ctl[C_HIIN]     = 1'b1;
            end
            default: ;
        endcase
    end

    assign halted  = (state == S_HALT);
    assign illegal = illegal_q;

endmodule

// File: tb/tb_control_sequencer.sv
// tb_control_sequencer
//   Self-checking bench for control_sequencer. A queue-based reference model
//   expands each instruction into its list of per-cycle strobe sets and
//   compares every cycle; directed scenarios add fixed-value checks.
//   Honours ILLEGAL_TRAP_EN the same way the design does.
module tb_control_sequencer;

    logic        clk = 1'b0;
    logic        reset, run, stop;
    logic [31:0] ir;
    logic [15:0] r_in, r_out, ctl;
    logic [12:0] alu_op;
    logic        halted, illegal;

    int errors = 0;
    int checks = 0;

    control_sequencer dut (
        .clk    (clk),
        .reset  (reset),
        .run    (run),
        .stop   (stop),
        .IR     (ir),
        .r_in   (r_in),
        .r_out  (r_out),
        .alu_op (alu_op),
        .ctl    (ctl),
        .halted (halted),
        .illegal(illegal)
    );

    always #5 clk = ~clk;

`ifdef ILLEGAL_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    typedef struct packed {
        logic [15:0] rin;
        logic [15:0] rout;
        logic [12:0] alu;
        logic [15:0] ctl;
    } cyc_t;

    // Reference model state: 0 idle, 1 running, 2 halted.
    int   m_mode = 0;
    cyc_t m_q[$];
    bit   m_decode = 0;
    bit   m_pend   = 0;
    bit   m_trap   = 0;
    bit   m_ill    = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic cyc_t mk(input logic [15:0] rin, input logic [15:0] rout,
                                input logic [12:0] alu, input logic [15:0] c);
        cyc_t x;
        x.rin = rin; x.rout = rout; x.alu = alu; x.ctl = c;
        return x;
    endfunction

    function automatic logic [15:0] oh(input logic [3:0] n);
        logic [15:0] one = 16'd1;
        return one << n;
    endfunction

    function automatic logic [15:0] cb(input int n);
        logic [15:0] one = 16'd1;
        return one << n;
    endfunction

    task automatic push_fetch();
        m_q.push_back(mk('0, '0, '0, 16'h000F));
        m_q.push_back(mk('0, '0, '0, 16'h01D0));
        m_q.push_back(mk('0, '0, '0, 16'h0600));
        m_decode = 1;
    endtask

    // Expand an instruction word into its execute-phase strobe list.
    task automatic push_exec(input logic [31:0] w);
        int          ab;
        logic [4:0]  op = w[31:27];
        logic [3:0]  ra = w[26:23];
        logic [3:0]  rb = w[22:19];
        logic [3:0]  rc = w[18:15];
        logic [12:0] alu;
        logic [12:0] one = 13'd1;
        case (op)
            5'd3: ab = 2;   5'd4: ab = 3;   5'd5: ab = 0;   5'd6: ab = 1;
            5'd7: ab = 9;   5'd8: ab = 10;  5'd9: ab = 6;   5'd10: ab = 7;
            5'd11: ab = 8;  5'd15: ab = 4;  5'd16: ab = 5;  5'd17: ab = 11;
            5'd18: ab = 12;
            default: ab = -1;
        endcase
        if (ab < 0) begin
            m_q.push_back(mk('0, '0, '0, '0));
            m_trap = TRAP;
        end else begin
            alu = one << ab;
            if (op == 5'd17 || op == 5'd18) begin
                m_q.push_back(mk('0, oh(rb), alu, cb(3)));
                m_q.push_back(mk(oh(ra), '0, '0, cb(4)));
            end else if (op == 5'd15 || op == 5'd16) begin
                m_q.push_back(mk('0, oh(ra), '0, cb(11)));
                m_q.push_back(mk('0, oh(rb), alu, cb(3)));
                m_q.push_back(mk('0, '0, '0, cb(4) | cb(13)));
                m_q.push_back(mk('0, '0, '0, cb(5) | cb(12)));
            end else begin
                m_q.push_back(mk('0, oh(rb), '0, cb(11)));
                m_q.push_back(mk('0, oh(rc), alu, cb(3)));
                m_q.push_back(mk(oh(ra), '0, '0, cb(4)));
            end
        end
    endtask

    task automatic model_edge();
        if (reset) begin
            m_mode = 0; m_q.delete(); m_decode = 0; m_pend = 0; m_trap = 0; m_ill = 0;
        end else if (m_mode != 1) begin
            if (run && !stop) begin
                m_mode = 1;
                push_fetch();
            end
        end else begin
            m_pend = m_pend | stop;
            void'(m_q.pop_front());
            if (m_q.size() == 0) begin
                if (m_decode) begin
                    m_decode = 0;
                    push_exec(ir);
                end else begin
                    if (m_trap || m_pend) begin
                        m_mode = 2;
                        if (m_trap) m_ill = 1;
                    end else begin
                        push_fetch();
                    end
                    m_pend = 0;
                    m_trap = 0;
                end
            end
        end
    endtask

    task automatic compare_all();
        cyc_t e = (m_mode == 1) ? m_q[0] : mk('0, '0, '0, '0);
        check_eq("r_in",    r_in,    e.rin);
        check_eq("r_out",   r_out,   e.rout);
        check_eq("alu_op",  alu_op,  e.alu);
        check_eq("ctl",     ctl,     e.ctl);
        check_eq("halted",  halted,  (m_mode == 2));
        check_eq("illegal", illegal, m_ill);
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        compare_all();
    endtask

    task automatic do_reset();
        reset = 1'b1; run = 1'b0; stop = 1'b0;
        step();
        reset = 1'b0;
    endtask

    task automatic start(input logic [31:0] w);
        ir = w; run = 1'b1;
        step();
        run = 1'b0;
    endtask

    logic [4:0] legal_ops[13] = '{5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd9,
                                  5'd10, 5'd11, 5'd15, 5'd16, 5'd17, 5'd18};

    initial begin
        reset = 1'b1; run = 1'b0; stop = 1'b0; ir = '0;
        step();
        do_reset();
        check_eq("rst_ctl",    ctl,    32'h0);
        check_eq("rst_rout",   r_out,  32'h0);
        check_eq("rst_halted", halted, 32'h0);

        // run and stop together in IDLE: stay idle
        run = 1'b1; stop = 1'b1; ir = 32'h18A38000;
        step();
        check_eq("idle_runstop_ctl", ctl, 32'h0);
        run = 1'b0; stop = 1'b0;

        // neg R5,R0
        do_reset();
        start(32'h8A800000);
        check_eq("neg_t0_ctl", ctl, 32'h000F);
        step(); check_eq("neg_t1_ctl", ctl, 32'h01D0);
        step(); check_eq("neg_t2_ctl", ctl, 32'h0600);
        step();
        check_eq("neg_t3_rout", r_out,  32'h0001);
        check_eq("neg_t3_alu",  alu_op, 32'h0800);
        check_eq("neg_t3_ctl",  ctl,    32'h0008);
        ir = 32'hFFFFFFFF;
        step();
        check_eq("neg_t4_ctl", ctl,  32'h0010);
        check_eq("neg_t4_rin", r_in, 32'h0020);
        step(); check_eq("neg_next_t0", ctl, 32'h000F);

        // add R1,R4,R7 with a stop pulse while in T1
        do_reset();
        start(32'h18A38000);
        step(); stop = 1'b1;
        step(); stop = 1'b0;
        step();
        check_eq("add_t3_rout", r_out, 32'h0010);
        check_eq("add_t3_ctl",  ctl,   32'h0800);
        step();
        check_eq("add_t4_rout", r_out,  32'h0080);
        check_eq("add_t4_alu",  alu_op, 32'h0004);
        check_eq("add_t4_ctl",  ctl,    32'h0008);
        step(); check_eq("add_t5_rin", r_in, 32'h0002);
        step();
        check_eq("stop_halted", halted, 32'h1);
        check_eq("stop_ctl",    ctl,    32'h0);
        step(); check_eq("stop_still_halted", halted, 32'h1);
        start(32'h18A38000);
        check_eq("resume_ctl",    ctl,    32'h000F);
        check_eq("resume_halted", halted, 32'h0);

        // mul R3,R2: 7-cycle instruction
        do_reset();
        start(32'h79900000);
        step(); step();
        step(); check_eq("mul_t3_rout", r_out, 32'h0008);
        step();
        check_eq("mul_t4_rout", r_out,  32'h0004);
        check_eq("mul_t4_alu",  alu_op, 32'h0010);
        step(); check_eq("mul_t5_ctl", ctl, 32'h2010);
        step(); check_eq("mul_t6_ctl", ctl, 32'h1020);
        step(); check_eq("mul_next_t0", ctl, 32'h000F);

        // reset in T4 of div
        do_reset();
        start(32'h81100000);
        step(); step(); step(); step();
        check_eq("div_t4_alu", alu_op, 32'h0020);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check_eq("div_rst_ctl",  ctl,    32'h0);
        check_eq("div_rst_rout", r_out,  32'h0);
        check_eq("div_rst_alu",  alu_op, 32'h0);

        // illegal opcode 11111
        do_reset();
        start(32'hF8000000);
        step(); step(); step();
        check_eq("ill_t3_ctl",  ctl,   32'h0);
        check_eq("ill_t3_rout", r_out, 32'h0);
        step();
        check_eq("ill_after_halted",  halted,  TRAP);
        check_eq("ill_after_illegal", illegal, TRAP);
        check_eq("ill_after_ctl",     ctl,     TRAP ? 32'h0 : 32'h000F);

        // randomized traffic against the model
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            reset = ($urandom_range(0, 299) == 0);
            run   = ($urandom_range(0, 3) == 0);
            stop  = ($urandom_range(0, 24) == 0);
            if ($urandom_range(0, 7) == 0)
                ir = $urandom;
            else
                ir = {legal_ops[$urandom_range(0, 12)], 27'($urandom)};
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
